// File: rtl/regfile_2w2r_sb_if.sv
// Operand-read, write-back and scoreboard-set signals between the pipeline and regfile_2w2r_sb.
interface regfile_2w2r_sb_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] iRAddr1;
    logic [ADDR_W-1:0] iRAddr2;
    logic [DATA_W-1:0] oData1;
    logic [DATA_W-1:0] oData2;
    logic              oPend1;
    logic              oPend2;
    logic              iWeA;
    logic [ADDR_W-1:0] iWAddrA;
    logic [DATA_W-1:0] iWDataA;
    logic              iWeB;
    logic [ADDR_W-1:0] iWAddrB;
    logic [DATA_W-1:0] iWDataB;
    logic              iSetPend;
    logic [ADDR_W-1:0] iSetAddr;
    logic              oWrConflict;

    modport master (
        output iRAddr1, iRAddr2, iWeA, iWAddrA, iWDataA, iWeB, iWAddrB, iWDataB, iSetPend, iSetAddr,
        input  oData1, oData2, oPend1, oPend2, oWrConflict
    );

    modport slave (
        input  iRAddr1, iRAddr2, iWeA, iWAddrA, iWDataA, iWeB, iWAddrB, iWDataB, iSetPend, iSetAddr,
        output oData1, oData2, oPend1, oPend2, oWrConflict
    );
endinterface

// File: rtl/regfile_2w2r_sb.sv
// Register file: two combinational reads, two prioritised writes (A over B),
// optional same-cycle write bypass and a per-register pending scoreboard.
module regfile_2w2r_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input logic              clk,
    input logic              reset,
    regfile_2w2r_sb_if.slave rf
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              wr_conflict_q;
    logic              wr_conflict_d;

    logic              wr_a_c;
    logic              wr_b_c;
    logic              keep_b_c;
    logic              set_c;
    logic [IDX_W-1:0]  idx_a;
    logic [IDX_W-1:0]  idx_b;
    logic [IDX_W-1:0]  idx_s;

    logic [ADDR_W-1:0] raddr_c [2];
    logic [DATA_W-1:0] rdata_c [2];
    logic              rpend_c [2];

    // Out-of-range addresses and the hardwired zero register are never targets.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    assign wr_a_c   = rf.iWeA && addr_ok(rf.iWAddrA);
    assign wr_b_c   = rf.iWeB && addr_ok(rf.iWAddrB);
    assign keep_b_c = wr_b_c && !(wr_a_c && (rf.iWAddrA == rf.iWAddrB));
    assign set_c    = rf.iSetPend && addr_ok(rf.iSetAddr);
    assign idx_a    = IDX_W'(rf.iWAddrA);
    assign idx_b    = IDX_W'(rf.iWAddrB);
    assign idx_s    = IDX_W'(rf.iSetAddr);

    // Next state: writes clear pending, a same-cycle set re-marks it (new producer wins).
    always_comb begin
        mem_d         = mem_q;
        pend_d        = pend_q;
        wr_conflict_d = wr_a_c && wr_b_c && (rf.iWAddrA == rf.iWAddrB);
        if (keep_b_c) begin
            mem_d[idx_b]  = rf.iWDataB;
            pend_d[idx_b] = 1'b0;
        end
        if (wr_a_c) begin
            mem_d[idx_a]  = rf.iWDataA;
            pend_d[idx_a] = 1'b0;
        end
        if (set_c) begin
            pend_d[idx_s] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q         <= '{default: '0};
            pend_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            pend_q        <= pend_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    assign raddr_c[0] = rf.iRAddr1;
    assign raddr_c[1] = rf.iRAddr2;

    // Read ports; with bypass a write hit overrides stored data and hides a stale pending bit.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_c[p] = '0;
            rpend_c[p] = 1'b0;
            if (addr_ok(raddr_c[p])) begin
                rdata_c[p] = mem_q[IDX_W'(raddr_c[p])];
                rpend_c[p] = pend_q[IDX_W'(raddr_c[p])];
                if (BYPASS && wr_b_c && (rf.iWAddrB == raddr_c[p])) begin
                    rdata_c[p] = rf.iWDataB;
                end
                if (BYPASS && wr_a_c && (rf.iWAddrA == raddr_c[p])) begin
                    rdata_c[p] = rf.iWDataA;
                end
                if (BYPASS
                    && ((wr_a_c && (rf.iWAddrA == raddr_c[p])) || (wr_b_c && (rf.iWAddrB == raddr_c[p])))
                    && !(set_c && (rf.iSetAddr == raddr_c[p]))) begin
                    rpend_c[p] = 1'b0;
                end
            end
        end
    end

    assign rf.oData1      = rdata_c[0];
    assign rf.oData2      = rdata_c[1];
    assign rf.oPend1      = rpend_c[0];
    assign rf.oPend2      = rpend_c[1];
    assign rf.oWrConflict = wr_conflict_q;
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Randomised bench for regfile_2w2r_sb: two configurations driven in lockstep against an array model.
module tb_regfile_2w2r_sb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]  ra1, ra2, waa, wab, seta;
    logic [31:0] wda, wdb;
    logic        wea, web, setp;

    int n_tests = 0;
    int n_fail  = 0;

    // Config 0: DEPTH 32, bypass, zero reg. Config 1: DEPTH 16, no bypass, reg 0 writable.
    int unsigned cfg_depth [2] = '{32, 16};
    bit          cfg_byp   [2] = '{1'b1, 1'b0};
    bit          cfg_zr    [2] = '{1'b1, 1'b0};

    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];
    bit          m_conf [2];

    regfile_2w2r_sb_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    regfile_2w2r_sb_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

    assign if0.iRAddr1 = ra1;  assign if1.iRAddr1 = ra1;
    assign if0.iRAddr2 = ra2;  assign if1.iRAddr2 = ra2;
    assign if0.iWeA = wea;     assign if1.iWeA = wea;
    assign if0.iWAddrA = waa;  assign if1.iWAddrA = waa;
    assign if0.iWDataA = wda;  assign if1.iWDataA = wda;
    assign if0.iWeB = web;     assign if1.iWeB = web;
    assign if0.iWAddrB = wab;  assign if1.iWAddrB = wab;
    assign if0.iWDataB = wdb;  assign if1.iWDataB = wdb;
    assign if0.iSetPend = setp; assign if1.iSetPend = setp;
    assign if0.iSetAddr = seta; assign if1.iSetAddr = seta;

    regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut0 (
        .clk(clk), .reset(reset), .rf(if0)
    );
    regfile_2w2r_sb #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut1 (
        .clk(clk), .reset(reset), .rf(if1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ok(input int c, input logic [4:0] a);
        return (32'(a) < cfg_depth[c]) && !(cfg_zr[c] && (a == 5'd0));
    endfunction

    function automatic bit m_hit(input int c, input logic [4:0] r);
        return (wea && m_ok(c, waa) && waa == r) || (web && m_ok(c, wab) && wab == r);
    endfunction

    function automatic logic [31:0] m_rdata(input int c, input logic [4:0] r);
        if (!m_ok(c, r)) return 32'd0;
        if (cfg_byp[c] && wea && m_ok(c, waa) && waa == r) return wda;
        if (cfg_byp[c] && web && m_ok(c, wab) && wab == r) return wdb;
        return m_mem[c][r];
    endfunction

    function automatic bit m_rpend(input int c, input logic [4:0] r);
        if (!m_ok(c, r)) return 1'b0;
        if (cfg_byp[c] && m_hit(c, r) && !(setp && seta == r)) return 1'b0;
        return m_pend[c][r];
    endfunction

    task automatic m_step();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[c][i]  = 32'd0;
                    m_pend[c][i] = 1'b0;
                end
                m_conf[c] = 1'b0;
            end else begin
                m_conf[c] = wea && web && m_ok(c, waa) && m_ok(c, wab) && (waa == wab);
                if (web && m_ok(c, wab) && !(wea && waa == wab)) begin
                    m_mem[c][wab]  = wdb;
                    m_pend[c][wab] = 1'b0;
                end
                if (wea && m_ok(c, waa)) begin
                    m_mem[c][waa]  = wda;
                    m_pend[c][waa] = 1'b0;
                end
                if (setp && m_ok(c, seta)) m_pend[c][seta] = 1'b1;
            end
        end
    endtask

    // Compare every output at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            if (!reset) begin
                check($sformatf("c%0d data1 r%0d", c, ra1), (c == 0) ? if0.oData1 : if1.oData1, m_rdata(c, ra1));
                check($sformatf("c%0d data2 r%0d", c, ra2), (c == 0) ? if0.oData2 : if1.oData2, m_rdata(c, ra2));
                check($sformatf("c%0d pend1 r%0d", c, ra1), 32'((c == 0) ? if0.oPend1 : if1.oPend1), 32'(m_rpend(c, ra1)));
                check($sformatf("c%0d pend2 r%0d", c, ra2), 32'((c == 0) ? if0.oPend2 : if1.oPend2), 32'(m_rpend(c, ra2)));
            end
            check($sformatf("c%0d conflict", c), 32'((c == 0) ? if0.oWrConflict : if1.oWrConflict), 32'(m_conf[c]));
        end
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wea = 1'b0; waa = '0; wda = '0;
        web = 1'b0; wab = '0; wdb = '0;
        setp = 1'b0; seta = '0;
    endtask

    initial begin
        idle();
        ra1 = '0; ra2 = '0;
        reset = 1'b1;
        wea = 1'b1; waa = 5'd9; wda = 32'hDEAD;
        setp = 1'b1; seta = 5'd9;
        tick();
        tick();
        idle();
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            tick();
        end

        wea = 1'b1; waa = 5'd2; wda = 32'd1;
        tick();
        idle(); web = 1'b1; wab = 5'd1; wdb = 32'd2;
        tick();
        idle(); ra1 = 5'd2; ra2 = 5'd1;
        #1;
        check("dir a2b1 d1", if0.oData1, 32'd1);
        check("dir a2b1 d2", if0.oData2, 32'd2);
        tick();

        wea = 1'b1; waa = 5'd5; wda = 32'hAAAA;
        web = 1'b1; wab = 5'd5; wdb = 32'hBBBB;
        tick();
        idle(); ra1 = 5'd5;
        #1;
        check("dir conflict data", if0.oData1, 32'hAAAA);
        check("dir conflict pulse0", 32'(if0.oWrConflict), 32'd1);
        check("dir conflict pulse1", 32'(if1.oWrConflict), 32'd1);
        tick();
        check("dir conflict drop", 32'(if0.oWrConflict), 32'd0);

        ra1 = 5'd7; wea = 1'b1; waa = 5'd7; wda = 32'h1234;
        #1;
        check("dir bypass on", if0.oData1, 32'h1234);
        check("dir bypass off", if1.oData1, 32'd0);
        tick();
        idle();
        #1;
        check("dir bypass off next", if1.oData1, 32'h1234);

        wea = 1'b1; waa = 5'd0; wda = 32'hFFFF;
        setp = 1'b1; seta = 5'd0;
        tick();
        idle(); ra1 = 5'd0;
        #1;
        check("dir zero data", if0.oData1, 32'd0);
        check("dir zero pend", 32'(if0.oPend1), 32'd0);
        check("dir r0 data", if1.oData1, 32'hFFFF);
        check("dir r0 pend", 32'(if1.oPend1), 32'd1);
        wea = 1'b1; waa = 5'd20; wda = 32'h5555;
        tick();
        idle(); ra1 = 5'd20; ra2 = 5'd4;
        #1;
        check("dir oob read", if1.oData1, 32'd0);
        check("dir oob alias", if1.oData2, 32'd0);
        check("dir d32 reg20", if0.oData1, 32'h5555);
        tick();

        setp = 1'b1; seta = 5'd3;
        tick();
        idle(); ra1 = 5'd3;
        #1;
        check("dir pend set0", 32'(if0.oPend1), 32'd1);
        check("dir pend set1", 32'(if1.oPend1), 32'd1);
        web = 1'b1; wab = 5'd3; wdb = 32'h33;
        #1;
        check("dir pend wr byp", 32'(if0.oPend1), 32'd0);
        check("dir pend wr nobyp", 32'(if1.oPend1), 32'd1);
        tick();
        idle();
        #1;
        check("dir pend clr0", 32'(if0.oPend1), 32'd0);
        check("dir pend clr1", 32'(if1.oPend1), 32'd0);
        setp = 1'b1; seta = 5'd3; wea = 1'b1; waa = 5'd3; wda = 32'h44;
        tick();
        idle();
        #1;
        check("dir set wins0", 32'(if0.oPend1), 32'd1);
        check("dir set wins1", 32'(if1.oPend1), 32'd1);
        tick();

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            wea  = ($urandom_range(0, 1) == 1);
            waa  = 5'($urandom_range(0, 31));
            wda  = $urandom;
            web  = ($urandom_range(0, 1) == 1);
            wab  = ($urandom_range(0, 3) == 0) ? waa : 5'($urandom_range(0, 31));
            wdb  = $urandom;
            setp = ($urandom_range(0, 2) == 0);
            seta = ($urandom_range(0, 3) == 0) ? waa : 5'($urandom_range(0, 31));
            ra1  = ($urandom_range(0, 3) == 0) ? waa : 5'($urandom_range(0, 31));
            ra2  = ($urandom_range(0, 3) == 0) ? wab : 5'($urandom_range(0, 31));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
